inv_mix_add_stage: RTL and testbench

Registered decryption-round stage that consumes the 128-bit output of the inverse SubBytes layer. It performs AddRoundKey and then InvMixColumns, skipping InvMixColumns on the final round. It sits between the inverse S-box layer and the round-state register / next InvShiftRows. It is a 2-deep valid/ready pipeline, so an iterative or unrolled decryptor can apply back-pressure.

---
 rtl/aes_pkg.sv | 72 +++++++
 rtl/inv_mix_column.sv | 21 ++
 rtl/inv_mix_add_stage.sv | 121 ++++++++++++
 tb/tb_inv_mix_add_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES decryption types and GF(2^8) helpers used by the inverse round datapath.
// Column/byte order: column 0 is bits [127:96], and the row-0 byte of each column is its top byte.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    localparam logic [7:0] AES_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Constant multipliers are built from the x2/x4/x8 chain so that
    // each one reduces to a small XOR tree.
    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic aes_word_t col(input aes_state_t s, input logic [1:0] i);
        aes_word_t w;
        case (i)
            2'd0:    w = s[127:96];
            2'd1:    w = s[95:64];
            2'd2:    w = s[63:32];
            default: w = s[31:0];
        endcase
        return w;
    endfunction

    function automatic aes_state_t set_col(input aes_state_t s, input logic [1:0] i,
                                           input aes_word_t w);
        aes_state_t r;
        r = s;
        case (i)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns for one 32-bit column; the top byte of the column is row 0.
module inv_mix_column
    import aes_pkg::*;
(
    input  aes_word_t col_in,
    output aes_word_t col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    assign col_out[23:16] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    assign col_out[15:8]  = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    assign col_out[7:0]   = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);

endmodule

// File: rtl/inv_mix_add_stage.sv
// Decryption round stage: AddRoundKey then InvMixColumns (bypassed on the final round), 2-deep valid/ready.
// Optional macro INV_MIX_ADD_STAGE_COUNT_EN adds the blk_count output-transfer counter.
module inv_mix_add_stage
    import aes_pkg::*;
#(
    parameter int PIPE_MID = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last
`ifdef INV_MIX_ADD_STAGE_COUNT_EN
    ,
    output logic [31:0]  blk_count
`endif
);

    aes_state_t ark_p0;
    aes_state_t mix_src;
    logic       last_src;
    logic       vld_src;
    aes_state_t mixed;
    aes_word_t  mix_cols [4];
    logic       can_load_p2;

    aes_state_t state_p2;
    logic       last_p2;
    logic       vld_p2;

    assign ark_p0      = in_state ^ in_key;
    assign can_load_p2 = !vld_p2 || out_ready;

    // ---- stage 0 -> 1: AddRoundKey result, registered only when PIPE_MID is set
    generate
        if (PIPE_MID != 0) begin : g_mid
            aes_state_t t_p1;
            logic       last_p1;
            logic       vld_p1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p1  <= 1'b0;
                    t_p1    <= '0;
                    last_p1 <= 1'b0;
                end else begin
                    if (in_ready) vld_p1 <= in_valid;
                    if (in_valid && in_ready) begin
                        t_p1    <= ark_p0;
                        last_p1 <= in_last;
                    end
                end
            end

            assign in_ready = !vld_p1 || can_load_p2;
            assign mix_src  = t_p1;
            assign last_src = last_p1;
            assign vld_src  = vld_p1;
        end else begin : g_flat
            assign in_ready = can_load_p2;
            assign mix_src  = ark_p0;
            assign last_src = in_last;
            assign vld_src  = in_valid;
        end
    endgenerate

    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_column u_col (
            .col_in  (col(mix_src, 2'(c))),
            .col_out (mix_cols[c])
        );
    end

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed = set_col(mixed, 2'(c), mix_cols[c]);
        end
    end

    // ---- stage 1 -> 2: output register, holds while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            state_p2 <= '0;
            last_p2  <= 1'b0;
        end else if (can_load_p2) begin
            vld_p2 <= vld_src;
            if (vld_src) begin
                state_p2 <= last_src ? mix_src : mixed;
                last_p2  <= last_src;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_state = state_p2;
    assign out_last  = last_p2;

`ifdef INV_MIX_ADD_STAGE_COUNT_EN
    logic [31:0] blk_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
        end else if (vld_p2 && out_ready) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end

    assign blk_count = blk_cnt;
`endif

endmodule

// File: tb/tb_inv_mix_add_stage.sv
// Bench for inv_mix_add_stage (PIPE_MID=1): directed vectors plus randomized traffic against a
// shift-and-add GF(2^8) reference and an in-order scoreboard; covers blk_count when the macro is set.
module tb_inv_mix_add_stage;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_last;
`ifdef INV_MIX_ADD_STAGE_COUNT_EN
    logic [31:0]  blk_count;
    logic [31:0]  exp_count;
`endif

    inv_mix_add_stage #(.PIPE_MID(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_last  (out_last)
`ifdef INV_MIX_ADD_STAGE_COUNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] state;
        logic         last;
        int           cyc;
    } item_t;

    item_t        q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    bit           acc_last;
    bit           rdy_last;
    bit           hold_chk = 0;
    logic [127:0] held_state;
    logic         held_last;
    logic [127:0] last_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t, r;
        logic [7:0]   base [4];
        logic [7:0]   acc;
        base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        t = s ^ k;
        if (last) return t;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(base[(j - row + 4) % 4], t[127 - 8*(4*c + j) -: 8]);
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: caller has set inputs at the falling edge; check, log transfers, advance.
    task automatic step();
        item_t it;
        #1;
        rdy_last = in_ready;
        chk1("in_ready", in_ready, !(q.size() == 2) || out_ready);
        chk1("out_valid", out_valid, (q.size() > 0) && ((cyc - q[0].cyc) >= 2));
        if (hold_chk) begin
            chk128("stall_state", out_state, held_state);
            chk1("stall_last", out_last, held_last);
        end
        hold_chk   = out_valid && !out_ready;
        held_state = out_state;
        held_last  = out_last;
`ifdef INV_MIX_ADD_STAGE_COUNT_EN
        chk32("blk_count", blk_count, exp_count);
`endif
        if (out_valid && out_ready && q.size() > 0) begin
            it = q.pop_front();
            chk128("out_state", out_state, it.state);
            chk1("out_last", out_last, it.last);
            last_out = out_state;
`ifdef INV_MIX_ADD_STAGE_COUNT_EN
            exp_count = exp_count + 32'd1;
`endif
        end
        acc_last = in_valid && in_ready;
        if (acc_last) begin
            it.state = ref_round(in_state, in_key, in_last);
            it.last  = in_last;
            it.cyc   = cyc;
            q.push_back(it);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic last);
        in_valid  = 1'b1;
        in_state  = s;
        in_key    = k;
        in_last   = last;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk32("drain_left", 32'(q.size()), 32'd0);
    endtask

    localparam logic [127:0] V_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_KEY = 128'h0123456789abcdef_fedcba9876543210;

    initial begin
        int sent;
        int drop_at;
        rst = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0; in_last = 1'b0; out_ready = 1'b1;
`ifdef INV_MIX_ADD_STAGE_COUNT_EN
        exp_count = '0;
`endif
        #2;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk128("rst_out_state", out_state, '0);
        chk1("rst_out_last", out_last, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("post_rst_in_ready", in_ready, 1'b1);

        send(V_IN, '0, 1'b0);
        drain();
        chk128("tp1_value", last_out, V_OUT);

        send(V_IN ^ V_KEY, V_KEY, 1'b0);
        drain();
        chk128("tp2_value", last_out, V_OUT);

        send(128'h00112233_44556677_8899aabb_ccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
        drain();
        chk128("tp3_value", last_out, 128'h00102030_40506070_8090a0b0_c0d0e0f0);

        // Back-pressure: out_ready low for cycles 2..5 of a 4-block stream.
        sent = 0; drop_at = -1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_last  = 1'b0;
        for (int k = 0; k < 14; k++) begin
            out_ready = !(k >= 2 && k <= 5);
            in_valid  = (sent < 4);
            step();
            if (in_valid && !rdy_last && drop_at < 0) drop_at = sent;
            if (acc_last) begin
                sent++;
                in_state = {$urandom, $urandom, $urandom, $urandom};
                in_key   = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        chk32("bp_ready_drop", 32'(drop_at), 32'd2);
        chk32("bp_sent", 32'(sent), 32'd4);
        drain();

        // Reset mid-stream with two blocks in flight.
        send({4{$urandom}}, {4{$urandom}}, 1'b0);
        send({4{$urandom}}, {4{$urandom}}, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk128("midrst_out_state", out_state, '0);
        chk1("midrst_out_last", out_last, 1'b0);
        q.delete();
        hold_chk = 0;
`ifdef INV_MIX_ADD_STAGE_COUNT_EN
        exp_count = '0;
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("midrst_in_ready", in_ready, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic with random stalls and final-round flags.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            in_key    = {$urandom, $urandom, $urandom, $urandom};
            in_last   = 1'($urandom_range(0, 1));
            step();
        end
        drain();

`ifdef INV_MIX_ADD_STAGE_COUNT_EN
        force dut.blk_cnt = 32'hFFFFFFFF;
        #1;
        release dut.blk_cnt;
        exp_count = 32'hFFFFFFFF;
        send({4{$urandom}}, {4{$urandom}}, 1'b0);
        drain();
        #1;
        chk32("count_wrap", blk_count, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
